// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: FSM state encodings and default frame parameters.
// Used by both the TX serializer and the RX side so encodings stay in lockstep.
package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_OS      = 16;
  localparam int DEF_SB_TICK = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, DBIT data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit (RX must use the same setting).
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int OS      = DEF_OS,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] d_in,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int TW = ($clog2(max2(OS, SB_TICK)) > 0) ? $clog2(max2(OS, SB_TICK)) : 1;
  localparam int BW = ($clog2(DBIT) > 0) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OS - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  state_t          r_state;
  logic [TW-1:0]   r_tick;
  logic [BW-1:0]   r_bit;
  logic [DBIT-1:0] r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;
`ifdef UART_TX_PARITY_EN
  logic            r_par;
`endif

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          // s_tick in the accept cycle is deliberately not counted
          if (tx_start) begin
            r_shift <= d_in;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^d_in;
`endif
            r_tick  <= '0;
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: if (s_tick) begin
          if (r_tick == OS_LAST) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        ST_DATA: if (s_tick) begin
          if (r_tick == OS_LAST) begin
            r_tick  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_par;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (s_tick) begin
          if (r_tick == OS_LAST) begin
            r_tick  <= '0;
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`endif
        ST_STOP: if (s_tick) begin
          if (r_tick == SB_LAST) begin
            r_tick  <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
